wb_s16_sram_ctrl: RTL

- 16-bit Wishbone classic slave that sits directly downstream of the 32-to-16 bridge and consumes its 16-bit master bus.
- Converts each Wishbone cycle into one access on an external asynchronous 16-bit SRAM, with programmable wait states and byte-lane control.
- Decodes out-of-range addresses to an error response, so the bridge's err path is exercised end to end.

---
 rtl/wb_s16_sram_ctrl_if.sv | 23 ++
 rtl/wb_s16_sram_ctrl.sv | 121 ++++++++++++
 2 files changed

// File: rtl/wb_s16_sram_ctrl_if.sv
// wb_s16_sram_ctrl_if: 16-bit Wishbone classic bus between the bridge master and the SRAM controller
interface wb_s16_sram_ctrl_if #(
  parameter int ADDRESS_WIDTH = 32
);
  logic                     wb_s_cyc_i;
  logic                     wb_s_stb_i;
  logic                     wb_s_we_i;
  logic [ADDRESS_WIDTH-1:0] wb_s_adr_i;
  logic [1:0]               wb_s_sel_i;
  logic [15:0]              wb_s_dat_i;
  logic [15:0]              wb_s_dat_o;
  logic                     wb_s_ack_o;
  logic                     wb_s_err_o;
  logic                     wb_s_rty_o;
  modport slave (
    input  wb_s_cyc_i, wb_s_stb_i, wb_s_we_i, wb_s_adr_i, wb_s_sel_i, wb_s_dat_i,
    output wb_s_dat_o, wb_s_ack_o, wb_s_err_o, wb_s_rty_o
  );
  modport master (
    output wb_s_cyc_i, wb_s_stb_i, wb_s_we_i, wb_s_adr_i, wb_s_sel_i, wb_s_dat_i,
    input  wb_s_dat_o, wb_s_ack_o, wb_s_err_o, wb_s_rty_o
  );
endinterface

// File: rtl/wb_s16_sram_ctrl.sv
// wb_s16_sram_ctrl: Wishbone classic 16-bit slave driving an async 16-bit SRAM with programmable wait states
module wb_s16_sram_ctrl #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int SRAM_AW       = 18,
  parameter int WAIT_STATES   = 2
) (
  input  logic               clk,
  input  logic               reset,
  wb_s16_sram_ctrl_if.slave  wb,
  output logic [SRAM_AW-1:0] sram_addr_o,
  output logic [15:0]        sram_dq_o,
  output logic               sram_dq_oe_o,
  input  logic [15:0]        sram_dq_i,
  output logic               sram_ce_n_o,
  output logic               sram_oe_n_o,
  output logic               sram_we_n_o,
  output logic               sram_lb_n_o,
  output logic               sram_ub_n_o
);
  typedef enum logic [1:0] {IDLE, ACCESS, HOLD, ERR} state_t;
  state_t state, state_nx;
  logic [3:0] cnt, cnt_nx;
  logic we_r, we_nx, ack_nx, err_nx, dq_oe_nx, ce_n_nx, oe_n_nx, we_n_nx, lb_n_nx, ub_n_nx;
  logic [15:0] dat_nx, dq_nx;
  logic [SRAM_AW-1:0] addr_nx;
  logic req, in_range;
  assign req = wb.wb_s_cyc_i && wb.wb_s_stb_i;
  assign in_range = wb.wb_s_adr_i[ADDRESS_WIDTH-1:SRAM_AW+1] == '0;
  assign wb.wb_s_rty_o = 1'b0;
  // Every output is a register loaded with its value for the state being entered.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    we_nx    = we_r;
    ack_nx   = 1'b0;
    err_nx   = 1'b0;
    dat_nx   = wb.wb_s_dat_o;
    addr_nx  = sram_addr_o;
    dq_nx    = sram_dq_o;
    dq_oe_nx = sram_dq_oe_o;
    ce_n_nx  = sram_ce_n_o;
    oe_n_nx  = 1'b1;
    we_n_nx  = 1'b1;
    lb_n_nx  = sram_lb_n_o;
    ub_n_nx  = sram_ub_n_o;
    case (state)
      IDLE: if (req && !in_range) begin
        state_nx = ERR;
        err_nx   = 1'b1;
      end else if (req) begin
        state_nx = ACCESS;
        cnt_nx   = 4'(WAIT_STATES);
        we_nx    = wb.wb_s_we_i;
        addr_nx  = wb.wb_s_adr_i[SRAM_AW:1];
        dq_nx    = wb.wb_s_we_i ? wb.wb_s_dat_i : sram_dq_o;
        dq_oe_nx = wb.wb_s_we_i;
        ce_n_nx  = 1'b0;
        oe_n_nx  = wb.wb_s_we_i;
        we_n_nx  = !wb.wb_s_we_i;
        lb_n_nx  = !wb.wb_s_sel_i[0];
        ub_n_nx  = !wb.wb_s_sel_i[1];
      end
      ACCESS: if (!wb.wb_s_cyc_i) begin
        state_nx = IDLE;
        ce_n_nx  = 1'b1;
        dq_oe_nx = 1'b0;
        lb_n_nx  = 1'b1;
        ub_n_nx  = 1'b1;
      end else if (cnt == 4'd0) begin
        state_nx = HOLD;
        ack_nx   = 1'b1;
        dat_nx   = we_r ? wb.wb_s_dat_o : sram_dq_i;
      end else begin
        cnt_nx  = cnt - 4'd1;
        oe_n_nx = we_r;
        we_n_nx = !we_r;
      end
      HOLD: begin
        state_nx = IDLE;
        ce_n_nx  = 1'b1;
        dq_oe_nx = 1'b0;
        lb_n_nx  = 1'b1;
        ub_n_nx  = 1'b1;
      end
      ERR: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state          <= IDLE;
      cnt            <= '0;
      we_r           <= 1'b0;
      wb.wb_s_ack_o  <= 1'b0;
      wb.wb_s_err_o  <= 1'b0;
      wb.wb_s_dat_o  <= '0;
      sram_addr_o    <= '0;
      sram_dq_o      <= '0;
      sram_dq_oe_o   <= 1'b0;
      sram_ce_n_o    <= 1'b1;
      sram_oe_n_o    <= 1'b1;
      sram_we_n_o    <= 1'b1;
      sram_lb_n_o    <= 1'b1;
      sram_ub_n_o    <= 1'b1;
    end else begin
      state          <= state_nx;
      cnt            <= cnt_nx;
      we_r           <= we_nx;
      wb.wb_s_ack_o  <= ack_nx;
      wb.wb_s_err_o  <= err_nx;
      wb.wb_s_dat_o  <= dat_nx;
      sram_addr_o    <= addr_nx;
      sram_dq_o      <= dq_nx;
      sram_dq_oe_o   <= dq_oe_nx;
      sram_ce_n_o    <= ce_n_nx;
      sram_oe_n_o    <= oe_n_nx;
      sram_we_n_o    <= we_n_nx;
      sram_lb_n_o    <= lb_n_nx;
      sram_ub_n_o    <= ub_n_nx;
    end
  end
endmodule
